// File: rtl/mc14500_seq_pkg.sv
// ============================================================================
// Module  : mc14500_seq_pkg
// Brief   : Instruction encoding shared by the MC14500-style sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mc14500_seq_pkg;

    localparam int c_OPC_W = 4;

    typedef enum logic [c_OPC_W-1:0] {
        OP_NOPO = 4'h0,
        OP_LD   = 4'h1,
        OP_LDC  = 4'h2,
        OP_AND  = 4'h3,
        OP_ANDC = 4'h4,
        OP_OR   = 4'h5,
        OP_ORC  = 4'h6,
        OP_XNOR = 4'h7,
        OP_STO  = 4'h8,
        OP_STOC = 4'h9,
        OP_IEN  = 4'hA,
        OP_OEN  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RTN  = 4'hD,
        OP_SKZ  = 4'hE,
        OP_NOPF = 4'hF
    } opcode_e;

    // Logic-unit result for the data-consuming opcodes; others keep rr.
    function automatic logic alu_result(input opcode_e op, input logic rr, input logic d);
        logic res;
        res = rr;
        case (op)
            OP_LD:   res = d;
            OP_LDC:  res = ~d;
            OP_AND:  res = rr & d;
            OP_ANDC: res = rr & ~d;
            OP_OR:   res = rr | d;
            OP_ORC:  res = rr | ~d;
            OP_XNOR: res = ~(rr ^ d);
            default: res = rr;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc14500_seq_icu_stack.sv
// ============================================================================
// Module  : icu_stack
// Brief   : Return-address LIFO; overflowing pushes and empty pops are ignored.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module icu_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] top
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_mem [2**c_IDX_W];
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_cnt == c_CNT_W'(DEPTH));
    assign empty     = (r_cnt == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign w_wr_idx  = r_cnt[c_IDX_W-1:0];
    assign w_rd_idx  = c_IDX_W'(r_cnt - c_CNT_W'(1));
    assign top       = r_mem[w_rd_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_do_push) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end else if (w_do_pop) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    // Storage needs no reset: only the occupancy count defines validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mc14500_seq.sv
// ============================================================================
// Module  : mc14500_seq
// Brief   : MC14500-style 1-bit industrial control sequencer with return stack.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mc14500_seq
    import mc14500_seq_pkg::*;
#(
    parameter int INPUT       = 5,
    parameter int OUTPUT      = 5,
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [c_OPC_W+PC_W-1:0] instr,
    output logic [PC_W-1:0]         pc,
    input  logic [INPUT-1:0]        input_pins,
    output logic [OUTPUT-1:0]       output_pins,
    output logic                    rr,
    output logic                    flag_o,
    output logic                    flag_f,
    output logic                    stk_err
);

    logic [PC_W-1:0]   r_pc;
    logic              r_rr;
    logic              r_ien;
    logic              r_oen;
    logic [OUTPUT-1:0] r_out;
    logic              r_flag_o;
    logic              r_flag_f;
    logic              r_stk_err;

    opcode_e           w_op;
    logic [PC_W-1:0]   w_operand;
    logic [31:0]       w_opnd32;
    logic              w_rd;
    logic              w_d;
    logic [OUTPUT-1:0] w_out_nxt;
    logic [PC_W-1:0]   w_pc_nxt;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [PC_W-1:0]   w_top;
    logic              w_err_set;

    assign w_op      = opcode_e'(instr[PC_W +: c_OPC_W]);
    assign w_operand = instr[PC_W-1:0];
    assign w_opnd32  = 32'(w_operand);
    assign w_d       = w_rd & r_ien;

    // Operand space: inputs first, then output latches, everything else is rr.
    always_comb begin
        w_rd = r_rr;
        for (int i = 0; i < INPUT; i++) begin
            if (w_opnd32 == 32'(i)) w_rd = input_pins[i];
        end
        for (int j = 0; j < OUTPUT; j++) begin
            if (w_opnd32 == 32'(INPUT + j)) w_rd = r_out[j];
        end
    end

    always_comb begin
        w_out_nxt = r_out;
        if ((w_op == OP_STO || w_op == OP_STOC) && r_oen) begin
            for (int j = 0; j < OUTPUT; j++) begin
                if (w_opnd32 == 32'(INPUT + j)) w_out_nxt[j] = (w_op == OP_STOC) ? ~r_rr : r_rr;
            end
        end
    end

    always_comb begin
        w_pc_nxt = r_pc + PC_W'(1);
        case (w_op)
            OP_SKZ:  if (!r_rr) w_pc_nxt = r_pc + PC_W'(2);
            OP_JMP:  w_pc_nxt = w_operand;
            OP_RTN:  if (!w_empty) w_pc_nxt = w_top;
            default: w_pc_nxt = r_pc + PC_W'(1);
        endcase
    end

    assign w_push    = en && (w_op == OP_JMP);
    assign w_pop     = en && (w_op == OP_RTN);
    assign w_err_set = (w_op == OP_JMP && w_full) || (w_op == OP_RTN && w_empty);

    icu_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_W)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (r_pc + PC_W'(1)),
        .full      (w_full),
        .empty     (w_empty),
        .top       (w_top)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc      <= '0;
            r_rr      <= 1'b0;
            r_ien     <= 1'b0;
            r_oen     <= 1'b0;
            r_out     <= '0;
            r_flag_o  <= 1'b0;
            r_flag_f  <= 1'b0;
            r_stk_err <= 1'b0;
        end else begin
            // Flags are single-cycle pulses, so they fall back whenever not re-armed.
            r_flag_o <= 1'b0;
            r_flag_f <= 1'b0;
            if (en) begin
                r_pc     <= w_pc_nxt;
                r_rr     <= alu_result(w_op, r_rr, w_d);
                r_out    <= w_out_nxt;
                r_flag_o <= (w_op == OP_NOPO);
                r_flag_f <= (w_op == OP_NOPF);
                if (w_op == OP_IEN) r_ien <= w_rd;
                if (w_op == OP_OEN) r_oen <= w_rd;
                if (w_err_set) r_stk_err <= 1'b1;
            end
        end
    end

    assign pc          = r_pc;
    assign rr          = r_rr;
    assign output_pins = r_out;
    assign flag_o      = r_flag_o;
    assign flag_f      = r_flag_f;
    assign stk_err     = r_stk_err;

endmodule

`default_nettype wire

// File: tb/tb_mc14500_seq.sv
// ============================================================================
// Module  : tb_mc14500_seq
// Brief   : Directed-vector scoreboard bench for mc14500_seq.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc14500_seq;
    import mc14500_seq_pkg::*;

    typedef struct {
        string nm;
        int    pc;
        int    rr;
        int    out;
        int    fo;
        int    ff;
        int    err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [11:0] instr;
    logic [7:0]  pc;
    logic [4:0]  input_pins;
    logic [4:0]  output_pins;
    logic        rr;
    logic        flag_o;
    logic        flag_f;
    logic        stk_err;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    mc14500_seq #(
        .INPUT       (5),
        .OUTPUT      (5),
        .PC_W        (8),
        .STACK_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .instr       (instr),
        .pc          (pc),
        .input_pins  (input_pins),
        .output_pins (output_pins),
        .rr          (rr),
        .flag_o      (flag_o),
        .flag_f      (flag_f),
        .stk_err     (stk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
        end
    endtask

    // Monitor: every edge produces a state snapshot; compare it against the oldest prediction.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                x = q.pop_front();
                chk(x.nm, "pc", int'(pc), x.pc);
                chk(x.nm, "rr", int'(rr), x.rr);
                chk(x.nm, "out", int'(output_pins), x.out);
                chk(x.nm, "flag_o", int'(flag_o), x.fo);
                chk(x.nm, "flag_f", int'(flag_f), x.ff);
                chk(x.nm, "stk_err", int'(stk_err), x.err);
            end
        end
    end

    task automatic s(input logic r_n, input logic e, input opcode_e op, input int opd,
                     input int epc, input int err_rr, input int eout, input int efo,
                     input int eff, input int eerr, input string nm);
        logic [7:0] o8;
        exp_t x;
        o8    = opd[7:0];
        rst   = r_n;
        en    = e;
        instr = {op, o8};
        @(posedge clk);
        #1;
        x.nm = nm; x.pc = epc; x.rr = err_rr; x.out = eout;
        x.fo = efo; x.ff = eff; x.err = eerr;
        q.push_back(x);
    endtask

    initial begin
        rst        = 1'b0;
        en         = 1'b0;
        instr      = '0;
        input_pins = 5'b10101;

        //   rst en op       opd    pc  rr out fo ff err
        s(0, 1, OP_NOPO, 0,      0, 0, 0, 0, 0, 0, "reset");
        s(0, 0, OP_LD,   0,      0, 0, 0, 0, 0, 0, "reset_en0");
        s(1, 1, OP_ORC,  15,     1, 1, 0, 0, 0, 0, "orc15");
        s(1, 1, OP_IEN,  15,     2, 1, 0, 0, 0, 0, "ien15");
        s(1, 1, OP_OEN,  15,     3, 1, 0, 0, 0, 0, "oen15");
        s(1, 1, OP_LD,   2,      4, 1, 0, 0, 0, 0, "ld2");
        s(1, 1, OP_STO,  5,      5, 1, 1, 0, 0, 0, "sto5");
        s(1, 1, OP_LDC,  1,      6, 1, 1, 0, 0, 0, "ldc1");
        s(1, 1, OP_STOC, 9,      7, 1, 1, 0, 0, 0, "stoc9");
        s(1, 1, OP_LD,   0,      8, 1, 1, 0, 0, 0, "ld0");
        s(1, 1, OP_STO,  7,      9, 1, 5, 0, 0, 0, "sto7");
        s(1, 1, OP_LD,   1,     10, 0, 5, 0, 0, 0, "ld1");
        s(1, 1, OP_SKZ,  0,     12, 0, 5, 0, 0, 0, "skz_rr0");
        s(1, 1, OP_AND,  0,     13, 0, 5, 0, 0, 0, "and0");
        s(1, 1, OP_OR,   2,     14, 1, 5, 0, 0, 0, "or2");
        s(1, 1, OP_ANDC, 0,     15, 0, 5, 0, 0, 0, "andc0");
        s(1, 1, OP_XNOR, 1,     16, 1, 5, 0, 0, 0, "xnor1");
        s(1, 1, OP_LD,   6,     17, 0, 5, 0, 0, 0, "ld_out1");
        s(1, 1, OP_ORC,  1,     18, 1, 5, 0, 0, 0, "orc1");
        s(1, 1, OP_JMP,  10,    10, 1, 5, 0, 0, 0, "jmp10");
        s(1, 1, OP_SKZ,  0,     11, 1, 5, 0, 0, 0, "skz_rr1");
        s(1, 1, OP_RTN,  0,     19, 1, 5, 0, 0, 0, "rtn19");
        s(1, 1, OP_NOPF, 0,     20, 1, 5, 0, 1, 0, "nopf");
        s(1, 1, OP_NOPO, 0,     21, 1, 5, 1, 0, 0, "nopo");
        for (int k = 0; k < 4; k++)
            s(1, 0, OP_STOC, 5, 21, 1, 5, 0, 0, 0, "stall");
        s(1, 1, OP_IEN,  6,     22, 1, 5, 0, 0, 0, "ien_clr");
        s(1, 1, OP_LD,   0,     23, 0, 5, 0, 0, 0, "ld_masked");
        s(1, 1, OP_OEN,  6,     24, 0, 5, 0, 0, 0, "oen_clr");
        s(1, 1, OP_LDC,  15,    25, 1, 5, 0, 0, 0, "ldc_rr");
        s(1, 1, OP_STO,  6,     26, 1, 5, 0, 0, 0, "sto_gated");
        s(1, 1, OP_IEN,  15,    27, 1, 5, 0, 0, 0, "ien_set");
        s(1, 1, OP_OEN,  15,    28, 1, 5, 0, 0, 0, "oen_set");
        s(1, 1, OP_STO,  6,     29, 1, 7, 0, 0, 0, "sto6");
        s(1, 1, OP_JMP,  'h40, 'h40, 1, 7, 0, 0, 0, "jmp_n1");
        s(1, 1, OP_JMP,  'h50, 'h50, 1, 7, 0, 0, 0, "jmp_n2");
        s(1, 1, OP_JMP,  'h60, 'h60, 1, 7, 0, 0, 0, "jmp_n3");
        s(1, 1, OP_JMP,  'h70, 'h70, 1, 7, 0, 0, 0, "jmp_n4");
        s(1, 1, OP_JMP,  'h80, 'h80, 1, 7, 0, 0, 1, "jmp_ovf");
        s(1, 1, OP_RTN,  0,   'h61, 1, 7, 0, 0, 1, "rtn_n4");
        s(1, 1, OP_RTN,  0,   'h51, 1, 7, 0, 0, 1, "rtn_n3");
        s(1, 1, OP_RTN,  0,   'h41, 1, 7, 0, 0, 1, "rtn_n2");
        s(1, 1, OP_RTN,  0,     30, 1, 7, 0, 0, 1, "rtn_n1");
        s(1, 1, OP_JMP,  'h90, 'h90, 1, 7, 0, 0, 1, "jmp_pre_rst");
        s(0, 1, OP_STO,  5,      0, 0, 0, 0, 0, 0, "rst_mid1");
        s(0, 1, OP_NOPF, 0,      0, 0, 0, 0, 0, 0, "rst_mid2");
        s(0, 0, OP_NOPO, 0,      0, 0, 0, 0, 0, 0, "rst_mid3");
        s(1, 1, OP_NOPO, 0,      1, 0, 0, 1, 0, 0, "run1");
        s(1, 1, OP_NOPO, 0,      2, 0, 0, 1, 0, 0, "run2");
        s(1, 1, OP_NOPO, 0,      3, 0, 0, 1, 0, 0, "run3");
        s(1, 1, OP_JMP,  'h40, 'h40, 0, 0, 0, 0, 0, "jmp40");
        s(1, 1, OP_RTN,  0,      4, 0, 0, 0, 0, 0, "rtn4");
        s(1, 1, OP_RTN,  0,      5, 0, 0, 0, 0, 1, "rtn_empty");
        s(1, 1, OP_JMP,  'hFF, 'hFF, 0, 0, 0, 0, 1, "jmp_ff");
        s(1, 1, OP_NOPO, 0,      0, 0, 0, 1, 0, 1, "wrap");
        s(1, 1, OP_ORC,  15,     1, 1, 0, 0, 0, 1, "orc_after_rst");
        s(1, 1, OP_LD,   0,      2, 0, 0, 0, 0, 1, "ld_ien_rst");
        s(1, 1, OP_SKZ,  0,      4, 0, 0, 0, 0, 1, "skz_final");

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
